// File: rtl/stim_pkg.sv
// stim_pkg: shared state encoding and default widths
// for the stim_source valid/ready stream generator.
package stim_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/stim_source_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/stim_source.sv
// stim_source: counted valid/ready word source with idle gaps,
// per-item stall measurement and a sticky stall timeout flag.
module stim_source
    import stim_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NUM_TX  = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 32,
    parameter int CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          dn_valid,
    output logic [DW-1:0] dn_data,
    input  logic          dn_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] tx_count,
    output logic [CW-1:0] max_wait,
    output logic          stall_err
);

    localparam logic [CW-1:0] NUM_LAST = CW'(NUM_TX);
    localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [CW:0]   TO_LIM   = (CW + 1)'(TIMEOUT);

    state_t        r_state;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_seq;
    logic [CW-1:0] r_tx;
    logic [CW-1:0] r_max;

    logic [CW-1:0] w_wait;
    logic [CW-1:0] w_gap;
    logic [CW-1:0] w_seq_inc;
    logic [CW-1:0] w_tx_inc;
    logic [CW:0]   w_wait_inc;
    logic          w_hs;
    logic          w_last;
    logic          w_gap_end;
    logic          w_timeout;
    logic          w_in_gap;

    assign w_hs       = r_valid & dn_ready;
    assign w_seq_inc  = r_seq + 1'b1;
    assign w_tx_inc   = r_tx + 1'b1;
    assign w_last     = (w_tx_inc == NUM_LAST);
    assign w_in_gap   = (r_state == S_GAP);
    assign w_gap_end  = (w_gap == GAP_LAST);
    assign w_wait_inc = {1'b0, w_wait} + 1'b1;
    assign w_timeout  = (w_wait_inc >= TO_LIM);

    // r_valid is high exactly while in SEND, so it gates the stall count
    sat_counter #(.W(CW)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~r_valid | w_hs),
        .i_inc (r_valid & ~dn_ready),
        .o_q   (w_wait)
    );

    sat_counter #(.W(CW)) u_gap (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~w_in_gap | w_gap_end),
        .i_inc (w_in_gap),
        .o_q   (w_gap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_seq   <= '0;
            r_tx    <= '0;
            r_max   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_data  <= '0;
                        r_seq   <= '0;
                        r_tx    <= '0;
                        r_max   <= '0;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_tx   <= w_tx_inc;
                        r_seq  <= w_seq_inc;
                        r_data <= DW'(w_seq_inc);
                        if (w_wait > r_max) begin
                            r_max <= w_wait;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (GAP == 0) begin
                            r_state <= S_SEND;
                        end else begin
                            r_state <= S_GAP;
                            r_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign dn_valid  = r_valid;
    assign dn_data   = r_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign tx_count  = r_tx;
    assign max_wait  = r_max;
    assign stall_err = r_err;

endmodule

// File: tb/tb_stim_source.sv
// tb_stim_source: random-backpressure bench for stim_source with a
// queue scoreboard and a transaction-level reference model.
module tb_stim_source;

    localparam int DW      = 16;
    localparam int CW      = 16;
    localparam int NUM_TX  = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 32;

    localparam int PH_IDLE = 0;
    localparam int PH_SEND = 1;
    localparam int PH_REST = 2;
    localparam int PH_FIN  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic          dn_ready = 1'b0;
    logic          dn_valid;
    logic [DW-1:0] dn_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] max_wait;
    logic          stall_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stim_source #(
        .DW      (DW),
        .NUM_TX  (NUM_TX),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dn_valid  (dn_valid),
        .dn_data   (dn_data),
        .dn_ready  (dn_ready),
        .busy      (busy),
        .done      (done),
        .tx_count  (tx_count),
        .max_wait  (max_wait),
        .stall_err (stall_err)
    );

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- sink: backpressure generator ----------------
    int rmode = 0;
    int vcnt  = 0;

    always @(posedge clk) begin
        if (dn_valid && dn_ready) vcnt = 0;
        else if (dn_valid) vcnt++;
        #2;
        case (rmode)
            0: dn_ready = 1'b1;
            1: dn_ready = (vcnt >= 4);
            2: dn_ready = 1'b0;
            default: dn_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    bit known = 0;
    int phase = PH_IDLE;
    int rest_left = 0;
    int stall_run = 0;
    int e_tx = 0;
    int e_max = 0;
    bit e_err = 0;

    always @(negedge clk) begin
        if (known) begin
            chk("dn_valid", dn_valid, phase == PH_SEND);
            chk("busy", busy, (phase == PH_SEND) || (phase == PH_REST));
            chk("done", done, phase == PH_FIN);
            chk("tx_count", tx_count, e_tx);
            chk("max_wait", max_wait, e_max);
            chk("stall_err", stall_err, e_err);
            if (phase == PH_SEND) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dn_data: got %0d, expected no word at %0t", dn_data, $time);
                end else begin
                    chk("dn_data", dn_data, exp_q[0]);
                end
            end
        end
        if (rst) begin
            known = 1;
            phase = PH_IDLE;
            e_tx = 0;
            e_max = 0;
            e_err = 0;
            stall_run = 0;
            exp_q.delete();
        end else if (known) begin
            case (phase)
                PH_IDLE, PH_FIN: begin
                    if (start) begin
                        phase = PH_SEND;
                        e_tx = 0;
                        e_max = 0;
                        e_err = 0;
                        stall_run = 0;
                        exp_q.delete();
                        for (int i = 0; i < NUM_TX; i++) exp_q.push_back(DW'(i));
                    end
                end
                PH_SEND: begin
                    if (dn_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        e_tx++;
                        if (stall_run > e_max) e_max = stall_run;
                        stall_run = 0;
                        if (e_tx == NUM_TX) phase = PH_FIN;
                        else if (GAP > 0) begin
                            phase = PH_REST;
                            rest_left = GAP;
                        end
                    end else begin
                        stall_run++;
                        if (stall_run >= TIMEOUT) e_err = 1;
                    end
                end
                default: begin
                    rest_left--;
                    if (rest_left == 0) phase = PH_SEND;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 600; i++) begin
            if (done) break;
            tick();
        end
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: done not seen within 600 cycles", nm);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        rmode = 0;
        repeat (3) tick();
        rst = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        chk("idle_valid", dn_valid, 0);

        pulse_start();
        wait_done("always_ready");
        chk("ar_tx", tx_count, NUM_TX);
        chk("ar_max", max_wait, 0);
        repeat (3) tick();

        rmode = 1;
        pulse_start();
        wait_done("delayed_ready");
        chk("dr_max", max_wait, 4);
        chk("dr_tx", tx_count, NUM_TX);
        repeat (2) tick();

        rmode = 2;
        pulse_start();
        repeat (40) tick();
        chk("stall_valid", dn_valid, 1);
        chk("stall_data", dn_data, 0);
        chk("stall_flag", stall_err, 1);
        rmode = 0;
        wait_done("stall_run");
        chk("stall_max", max_wait, 40);
        chk("stall_sticky", stall_err, 1);
        repeat (2) tick();

        rmode = 3;
        pulse_start();
        chk("restart_err", stall_err, 0);
        chk("restart_max", max_wait, 0);
        tick();
        pulse_start();
        wait_done("restart_run");

        rmode = 0;
        pulse_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", dn_valid, 0);
        chk("midrst_tx", tx_count, 0);
        repeat (2) tick();
        pulse_start();
        chk("midrst_data", dn_data, 0);
        wait_done("after_reset");

        for (int r = 0; r < 8; r++) begin
            rmode = 3;
            repeat ($urandom_range(0, 4)) tick();
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) tick();
                pulse_start();
            end
            wait_done("random_run");
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stim_source.md
# stim_source

Valid/ready stream source that produces a counted sequence of data words toward a downstream sink that may apply arbitrary backpressure, such as the delayed-ready checker. It owns the transmit side of the handshake: it holds valid and data stable until accepted, inserts programmable idle gaps, and reports how long the sink stalled. It serves as the stimulus generator in the BFM/tracker test harness.

## Interface
- DW, 16, data width
- NUM_TX, 8, transfers per run (>=1)
- GAP, 2, idle cycles between an accept and the next valid (0 = back-to-back)
- TIMEOUT, 32, stall cycles before stall_err is flagged (>=1)
- CW, 16, width of tx_count and max_wait
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  single-cycle run request
- dn_valid  out  1  data valid to sink
- dn_data  out  DW  data word, equals sequence index
- dn_ready  in  1  sink ready
- busy  out  1  run in progress (SEND or GAP)
- done  out  1  run complete, held until next start
- tx_count  out  CW  accepted transfers this run
- max_wait  out  CW  longest single-item stall this run
- stall_err  out  1  sticky, some item waited >= TIMEOUT cycles

## Operation
- States: IDLE, SEND, GAP, DONE. All outputs are registered.
- rst: state IDLE; dn_valid, dn_data, busy, done, tx_count, max_wait, stall_err, seq, wait_cnt, gap_cnt all 0. rst overrides start.
- IDLE/DONE + start: clear tx_count, max_wait, stall_err, seq; go to SEND. start is ignored in SEND/GAP.
- SEND: dn_valid=1, dn_data=seq[DW-1:0]. wait_cnt is 0 on entry and increments each SEND cycle without a handshake, saturating at all-ones.
- Handshake = dn_valid & dn_ready at a rising edge. On handshake: tx_count+1, seq+1, max_wait=max(max_wait, wait_cnt), wait_cnt=0. Next state: DONE if tx_count+1==NUM_TX, else SEND if GAP==0, else GAP.
- No handshake and wait_cnt+1 >= TIMEOUT: set stall_err. dn_valid stays high and dn_data stays unchanged. Valid is never withdrawn.
- GAP: dn_valid=0, gap_cnt counts GAP cycles, then SEND.
- DONE: dn_valid=0, done=1, busy=0. Counters hold.
- dn_ready is ignored while dn_valid=0.

## Timing
- start sampled at edge N: dn_valid high from cycle N+1.
- Handshake at end of cycle K with GAP=0: next word valid in cycle K+1. With GAP=g: dn_valid low for cycles K+1..K+g, high again in cycle K+g+1.
- Last handshake at end of cycle K: done=1 and busy=0 from cycle K+1.
- stall_err rises in the cycle after the TIMEOUT-th consecutive stalled cycle.
- Reset mid-run: dn_valid=0 in the cycle after the rst edge. No partial state is kept.

## Structure
- Shared package stim_pkg: state enum (IDLE, SEND, GAP, DONE) and the default constants for DW and CW.
- One sub-module, sat_counter (width, increment, clear, saturates at all-ones). It is instantiated for wait_cnt and gap_cnt.
- Width rules: seq is CW bits wide and truncated or zero-extended to DW. tx_count compare uses CW bits.

## Test plan
- Reset: assert rst for 3 cycles while start=1, then release -> all outputs 0 and state IDLE. No dn_valid until a later start.
- Always-ready sink, GAP=0, NUM_TX=4, start at edge 0 -> dn_data 0,1,2,3 in cycles 1–4, done=1 from cycle 5, tx_count=4, max_wait=0, stall_err=0.
- Delayed-ready sink that raises ready after 4 valid cycles and resets its count on accept, with GAP=2, NUM_TX=3, start at edge 0 -> dn_valid high in cycles 1–5, 8–12 and 15–19; accepts at the end of cycles 5, 12 and 19. Expected result: done from cycle 20, max_wait=4, tx_count=3.
- Stall: dn_ready=0 for 40 cycles with TIMEOUT=32 -> stall_err=1 after 32 stalled cycles, dn_valid and dn_data=0 held stable throughout. Then ready=1 -> accept, max_wait=40, stall_err stays 1.
- Reset mid-run: rst in cycle 3 of the always-ready case -> dn_valid=0 next cycle, tx_count=0. A new start restarts from data 0.
- Restart from DONE: start pulse after the stall case -> tx_count, max_wait and stall_err cleared, seq restarts at 0. start pulsed while busy has no effect.
